// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer datapath: FSM encoding and default word width.
package serdes_pkg;

    localparam int unsigned SER_WIDTH_DEF = 8;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } ser_state_e;

endpackage

// File: rtl/bit_shift_reg.sv
// Loadable shift register with direction select and bit counter; ser is the registered
// serial bit, cnt indexes the bit currently presented on ser.
module bit_shift_reg
    import serdes_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_WIDTH_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             ser,
    output logic             last
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sr_q, sr_d;
    logic             ser_q, ser_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    // A load presents the first bit immediately, so the stored copy is already advanced once.
    always_comb begin
        sr_d  = sr_q;
        ser_d = ser_q;
        cnt_d = cnt_q;
        if (clear) begin
            sr_d  = '0;
            ser_d = 1'b0;
            cnt_d = '0;
        end else if (load) begin
            sr_d  = advance(data);
            ser_d = head(data);
            cnt_d = '0;
        end else if (shift) begin
            sr_d  = advance(sr_q);
            ser_d = head(sr_q);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= '0;
            ser_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            ser_q <= ser_d;
            cnt_q <= cnt_d;
        end
    end

    assign ser  = ser_q;
    assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the sequence detector: one holding register in front of a
// shifter, so back-to-back words stream out with no idle bit between them.
module bit_serializer
    import serdes_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_WIDTH_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("bit_serializer: WIDTH must be within 2..32");
    end

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic             accept;
    logic             sh_load, sh_shift, sh_clear, sh_last, sh_ser;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (hold_full_q) state_d = StShift;
            StShift: if (sh_last && !hold_full_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    // Shifter control; clearing on the way to idle keeps x at 0 whenever x_valid is low.
    always_comb begin
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_clear = 1'b0;
        if (abort) begin
            sh_clear = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hold_full_q) sh_load = 1'b1;
                end
                StShift: begin
                    if (!sh_last)        sh_shift = 1'b1;
                    else if (hold_full_q) sh_load = 1'b1;
                    else                 sh_clear = 1'b1;
                end
                default: sh_clear = 1'b1;
            endcase
        end
    end

    // Accept and transfer never coincide: transfer needs hold full, accept needs it empty.
    assign accept = din_valid && !hold_full_q && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (abort || sh_load) begin
            hold_full_q <= 1'b0;
        end else if (accept) begin
            hold_q      <= din;
            hold_full_q <= 1'b1;
        end
    end

    bit_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .clear (sh_clear),
        .load  (sh_load),
        .shift (sh_shift),
        .data  (hold_q),
        .ser   (sh_ser),
        .last  (sh_last)
    );

    assign din_ready = !hold_full_q;
    assign x         = sh_ser;
    assign x_valid   = (state_q == StShift);
    assign word_done = (state_q == StShift) && sh_last;
    assign busy      = (state_q == StShift) || hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share stimulus and are
// compared each cycle against a FIFO-of-bits reference model, plus directed scenarios.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         abort;

    logic rdy_m, x_m, xv_m, wd_m, busy_m;
    logic rdy_l, x_l, xv_l, wd_l, busy_l;

    int n_cmp;
    int n_err;

    // Reference model, index 0 = MSB-first instance, 1 = LSB-first instance.
    logic [W-1:0] m_hold [2];
    bit           m_hf   [2];
    bit           fifo   [2][16];
    int           fcnt   [2];
    bit           ex     [2];
    bit           ev     [2];
    bit           ed     [2];

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (rdy_m),
        .abort     (abort),
        .x         (x_m),
        .x_valid   (xv_m),
        .word_done (wd_m),
        .busy      (busy_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (rdy_l),
        .abort     (abort),
        .x         (x_l),
        .x_valid   (xv_l),
        .word_done (wd_l),
        .busy      (busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear(input int d);
        fcnt[d] = 0;
        m_hf[d] = 1'b0;
        ex[d]   = 1'b0;
        ev[d]   = 1'b0;
        ed[d]   = 1'b0;
    endtask

    // One clock edge: a word drains as a list of bits; an empty list pulls in the held word.
    task automatic model_edge(input int d);
        bit           old_hf;
        logic [W-1:0] w;
        old_hf = m_hf[d];
        if (!rst || abort) begin
            model_clear(d);
            return;
        end
        if (fcnt[d] == 0 && old_hf) begin
            w = m_hold[d];
            for (int k = 0; k < W; k++) fifo[d][k] = (d == 0) ? w[W-1-k] : w[k];
            fcnt[d] = W;
            m_hf[d] = 1'b0;
        end
        if (fcnt[d] > 0) begin
            ex[d] = fifo[d][0];
            for (int k = 0; k < 15; k++) fifo[d][k] = fifo[d][k+1];
            fcnt[d]--;
            ev[d] = 1'b1;
            ed[d] = (fcnt[d] == 0);
        end else begin
            ex[d] = 1'b0;
            ev[d] = 1'b0;
            ed[d] = 1'b0;
        end
        if (din_valid && !old_hf) begin
            m_hold[d] = din;
            m_hf[d]   = 1'b1;
        end
    endtask

    function automatic logic [31:0] model_vec(input int d);
        return 32'({ex[d], ev[d], ed[d], !m_hf[d], ev[d] | m_hf[d]});
    endfunction

    task automatic check_outputs();
        check_eq("msb_outputs", 32'({x_m, xv_m, wd_m, rdy_m, busy_m}), model_vec(0));
        check_eq("lsb_outputs", 32'({x_l, xv_l, wd_l, rdy_l, busy_l}), model_vec(1));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_outputs();
    endtask

    // Non-overlapping 11011 detector standing in for the downstream block.
    logic [4:0] det_hist;
    int         det_hits;

    logic [15:0] col_m, col_l, wd_mask;
    int          run, max_run, idx;
    bit          acc;
    logic [7:0]  bw [2];

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        abort     = 1'b0;
        model_clear(0);
        model_clear(1);
        #1;
        check_eq("reset_msb", 32'({x_m, xv_m, wd_m, rdy_m, busy_m}), 32'b00010);
        check_eq("reset_lsb", 32'({x_l, xv_l, wd_l, rdy_l, busy_l}), 32'b00010);
        step();
        rst = 1'b1;

        // Single word, accepted on the first edge after reset release.
        din = 8'b11011000;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        col_m = '0; col_l = '0; wd_mask = '0;
        for (int i = 0; i < W; i++) begin
            step();
            col_m   = {col_m[14:0], x_m};
            col_l   = {col_l[14:0], x_l};
            wd_mask = {wd_mask[14:0], wd_m};
        end
        check_eq("single_msb_bits", 32'(col_m[7:0]), 32'h000000d8);
        check_eq("single_lsb_bits", 32'(col_l[7:0]), 32'h0000001b);
        check_eq("single_word_done", 32'(wd_mask[7:0]), 32'h00000001);
        step();
        check_eq("single_idle_after", 32'({x_m, xv_m}), 32'b00);

        // LSB-first with a single set bit.
        din = 8'h01;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        col_l = '0;
        for (int i = 0; i < W; i++) begin
            step();
            col_l = {col_l[14:0], x_l};
        end
        check_eq("lsb_first_01", 32'(col_l[7:0]), 32'h00000080);
        step();

        // Back-to-back words held valid.
        bw[0] = 8'hA5;
        bw[1] = 8'h3C;
        idx = 0; run = 0; max_run = 0; col_m = '0;
        for (int i = 0; i < 30; i++) begin
            din_valid = (idx < 2);
            din = (idx < 2) ? bw[idx] : 8'h00;
            acc = din_valid && !m_hf[0];
            step();
            if (acc) idx++;
            if (xv_m) begin
                run++;
                col_m = {col_m[14:0], x_m};
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
        end
        din_valid = 1'b0;
        check_eq("b2b_run", 32'(max_run), 32'd16);
        check_eq("b2b_bits", 32'(col_m), 32'h0000a53c);

        // Abort after the third bit, with a simultaneous offer.
        din = 8'hFF;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        abort = 1'b1;
        din = 8'h5A;
        din_valid = 1'b1;
        step();
        abort = 1'b0;
        din_valid = 1'b0;
        check_eq("abort_x", 32'({x_m, xv_m, wd_m}), 32'b000);
        check_eq("abort_hold_empty", 32'({rdy_m, busy_m}), 32'b10);
        run = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (xv_m) run++;
        end
        check_eq("abort_dropped", 32'(run), 32'd0);

        // Asynchronous reset in the middle of a word.
        din = 8'hAA;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #3;
        rst = 1'b0;
        #1;
        check_eq("async_rst_msb", 32'({x_m, xv_m, wd_m, rdy_m, busy_m}), 32'b00010);
        check_eq("async_rst_lsb", 32'({x_l, xv_l, wd_l, rdy_l, busy_l}), 32'b00010);
        step();
        #3;
        rst = 1'b1;
        din = 8'h5A;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        col_m = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (xv_m) col_m = {col_m[14:0], x_m};
        end
        check_eq("after_rst_word", 32'(col_m), 32'h0000005a);

        // End-to-end into the 11011 detector.
        det_hist = '0;
        det_hits = 0;
        din = 8'b11011011;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            det_hist = {det_hist[3:0], x_m};
            if (det_hist == 5'b11011) begin
                det_hits++;
                det_hist = '0;
            end
        end
        check_eq("detector_hits", 32'(det_hits), 32'd1);

        // Randomized traffic with occasional abort and reset.
        for (int i = 0; i < 3000; i++) begin
            din       = W'($urandom);
            din_valid = ($urandom_range(0, 99) < 60);
            abort     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 399) != 0);
            step();
        end
        rst = 1'b1;
        abort = 1'b0;
        din_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
